// File: rtl/fls_pkg.sv
// rtl/fls_pkg.sv - shared types, widths and sum helper for the FLS generator/checker pair
package fls_pkg;

    localparam int DEF_W = 8;
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        SEED0 = 2'd0,
        SEED1 = 2'd1,
        CHECK = 2'd2
    } fls_state_t;

    // Unsigned sum carrying the extra top bit; callers cast down to their own W+1
    function automatic logic [MAX_W:0] fls_sum(input logic [MAX_W-1:0] x, input logic [MAX_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage

// File: rtl/fls_edge_det.sv
// rtl/fls_edge_det.sv - rising-edge detector for the value strobe
module fls_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic stb
);

    logic en_q;

    // Delayed copy of en; clears to 0 so an en already high at reset release strobes once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    assign stb = en & ~en_q;

endmodule

// File: rtl/fls_checker.sv
// rtl/fls_checker.sv - seeds on the first two values, then checks each value is the sum of the previous two
module fls_checker
    import fls_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  exp,
    output logic          cf,
    output logic          match,
    output logic          err,
    output logic [CW-1:0] cnt,
    output logic [1:0]    state
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    fls_state_t   st;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         stb;

    fls_edge_det u_edge (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .stb (stb)
    );

    assign state = st;

    // Seed/check FSM with registered datapath; clr wins over a coincident strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= SEED0;
            a     <= '0;
            b     <= '0;
            exp   <= '0;
            cf    <= 1'b0;
            match <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else if (clr) begin
            st    <= SEED0;
            a     <= '0;
            b     <= '0;
            exp   <= '0;
            cf    <= 1'b0;
            match <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (st)
                SEED0: begin
                    if (stb) begin
                        a     <= d;
                        match <= 1'b1;
                        cnt   <= CW'(1);
                        st    <= SEED1;
                    end
                end
                SEED1: begin
                    if (stb) begin
                        b         <= d;
                        {cf, exp} <= (W+1)'(fls_sum(MAX_W'(a), MAX_W'(d)));
                        match     <= 1'b1;
                        cnt       <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                        st        <= CHECK;
                    end
                end
                CHECK: begin
                    if (stb) begin
                        match     <= (d == exp);
                        err       <= err | (d != exp);
                        // Resync on the received value so one bad value causes one mismatch
                        a         <= b;
                        b         <= d;
                        {cf, exp} <= (W+1)'(fls_sum(MAX_W'(b), MAX_W'(d)));
                        cnt       <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                    end
                end
                default: begin
                    st <= SEED0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fls_checker.sv
// tb/tb_fls_checker.sv - directed scoreboard bench for fls_checker
module tb_fls_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic [7:0] d;

    logic [7:0] exp8;
    logic       cf8;
    logic       match8;
    logic       err8;
    logic [7:0] cnt8;
    logic [1:0] state8;

    logic [7:0] exp3;
    logic       cf3;
    logic       match3;
    logic       err3;
    logic [2:0] cnt3;
    logic [1:0] state3;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] exp;
        logic       cf;
        logic       match;
        logic       err;
        logic [7:0] cnt;
        logic [2:0] cnt3;
        logic [1:0] state;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [1:0] m_state;
    logic [7:0] m_a, m_b, m_exp;
    logic       m_cf, m_match, m_err;
    logic [7:0] m_cnt;
    logic [2:0] m_cnt3;

    always #5 clk = ~clk;

    fls_checker #(.W(8), .CW(8)) dut (
        .clk (clk), .rst (rst), .en (en), .clr (clr), .d (d),
        .exp (exp8), .cf (cf8), .match (match8), .err (err8), .cnt (cnt8), .state (state8)
    );

    fls_checker #(.W(8), .CW(3)) dut3 (
        .clk (clk), .rst (rst), .en (en), .clr (clr), .d (d),
        .exp (exp3), .cf (cf3), .match (match3), .err (err3), .cnt (cnt3), .state (state3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_state = 2'd0; m_a = '0; m_b = '0; m_exp = '0;
        m_cf = 1'b0; m_match = 1'b0; m_err = 1'b0; m_cnt = '0; m_cnt3 = '0;
    endtask

    task automatic model_step(input logic s, input logic [7:0] v, input logic c);
        logic [8:0] sum;
        if (c) begin
            model_reset();
        end else if (s) begin
            if (m_state == 2'd0) begin
                m_a = v; m_match = 1'b1; m_cnt = 8'd1; m_cnt3 = 3'd1; m_state = 2'd1;
            end else begin
                sum = (m_state == 2'd1) ? ({1'b0, m_a} + {1'b0, v}) : ({1'b0, m_b} + {1'b0, v});
                if (m_state == 2'd2) begin
                    m_match = (v == m_exp);
                    m_err   = m_err | (v != m_exp);
                    m_a     = m_b;
                end else begin
                    m_match = 1'b1;
                end
                m_b = v;
                {m_cf, m_exp} = sum;
                m_state = 2'd2;
                if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
                if (m_cnt3 != 3'd7) m_cnt3 = m_cnt3 + 3'd1;
            end
        end
        sb.push_back('{exp: m_exp, cf: m_cf, match: m_match, err: m_err,
                       cnt: m_cnt, cnt3: m_cnt3, state: m_state});
    endtask

    // Inputs are already driven; predict, wait for the edge, then compare just after it
    task automatic expect_edge(input logic s, input logic [7:0] v, input logic c);
        exp_t e;
        model_step(s, v, c);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("exp",   32'(exp8),   32'(e.exp));
            chk("cf",    32'(cf8),    32'(e.cf));
            chk("match", 32'(match8), 32'(e.match));
            chk("err",   32'(err8),   32'(e.err));
            chk("cnt",   32'(cnt8),   32'(e.cnt));
            chk("cnt3",  32'(cnt3),   32'(e.cnt3));
            chk("state", 32'(state8), 32'(e.state));
        end
    endtask

    task automatic pulse(input logic [7:0] v, input logic c);
        @(negedge clk);
        en = 1'b0; clr = 1'b0;
        expect_edge(1'b0, 8'd0, 1'b0);
        @(negedge clk);
        d = v; en = 1'b1; clr = c;
        expect_edge(1'b1, v, c);
        clr = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        expect_edge(1'b0, 8'd0, 1'b1);
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; d = 8'd0;
        model_reset();

        // 1: reset state, then en high before reset release gives exactly one strobe
        #3;
        en = 1'b1; d = 8'd2;
        #3;
        chk("rst_state", 32'(state8), 32'd0);
        chk("rst_cnt",   32'(cnt8),   32'd0);
        chk("rst_match", 32'(match8), 32'd0);
        #2;
        rst = 1'b0;
        expect_edge(1'b1, 8'd2, 1'b0);
        chk("t1_cnt",   32'(cnt8),   32'd1);
        chk("t1_state", 32'(state8), 32'd1);
        chk("t1_match", 32'(match8), 32'd1);
        for (int i = 0; i < 3; i++) expect_edge(1'b0, 8'd2, 1'b0);
        chk("t1_hold_cnt", 32'(cnt8), 32'd1);

        // 2: seeds 2,3 then 5,8,13
        pulse(8'd3, 1'b0);
        chk("t2_exp5", 32'(exp8), 32'd5);
        pulse(8'd5, 1'b0);
        chk("t2_exp8", 32'(exp8), 32'd8);
        pulse(8'd8, 1'b0);
        chk("t2_exp13", 32'(exp8), 32'd13);
        pulse(8'd13, 1'b0);
        chk("t2_exp21", 32'(exp8), 32'd21);
        chk("t2_match", 32'(match8), 32'd1);
        chk("t2_err",   32'(err8),   32'd0);
        chk("t2_cnt",   32'(cnt8),   32'd5);
        chk("t2_cf",    32'(cf8),    32'd0);

        // 3: overflow / carry
        do_clr();
        pulse(8'd144, 1'b0);
        pulse(8'd233, 1'b0);
        chk("t3_exp121", 32'(exp8), 32'd121);
        chk("t3_cf1",    32'(cf8),  32'd1);
        pulse(8'd121, 1'b0);
        chk("t3_match", 32'(match8), 32'd1);
        chk("t3_exp98", 32'(exp8),   32'd98);
        chk("t3_cf2",   32'(cf8),    32'd1);

        // 4: mismatch then resync
        do_clr();
        pulse(8'd1, 1'b0);
        pulse(8'd1, 1'b0);
        pulse(8'd3, 1'b0);
        chk("t4_match0", 32'(match8), 32'd0);
        chk("t4_err1",   32'(err8),   32'd1);
        chk("t4_exp4",   32'(exp8),   32'd4);
        pulse(8'd4, 1'b0);
        chk("t4_match1",  32'(match8), 32'd1);
        chk("t4_err_sticky", 32'(err8), 32'd1);

        // 5: clr with a coincident strobe discards the value
        pulse(8'd50, 1'b1);
        chk("t5_state", 32'(state8), 32'd0);
        chk("t5_cnt",   32'(cnt8),   32'd0);
        chk("t5_err",   32'(err8),   32'd0);
        chk("t5_match", 32'(match8), 32'd0);
        pulse(8'd10, 1'b0);
        pulse(8'd20, 1'b0);
        chk("t5_reseed_exp",   32'(exp8),   32'd30);
        chk("t5_reseed_state", 32'(state8), 32'd2);
        chk("t5_reseed_cnt",   32'(cnt8),   32'd2);
        pulse(8'd30, 1'b0);

        // 6: async reset between edges takes effect immediately
        @(posedge clk);
        #3;
        rst = 1'b1; en = 1'b0;
        #1;
        chk("t6_state", 32'(state8), 32'd0);
        chk("t6_cnt",   32'(cnt8),   32'd0);
        chk("t6_exp",   32'(exp8),   32'd0);
        chk("t6_cf",    32'(cf8),    32'd0);
        chk("t6_match", 32'(match8), 32'd0);
        chk("t6_cnt3",  32'(cnt3),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // 6b: counter saturation on the CW=3 instance
        begin
            logic [7:0] fib [9];
            fib = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34};
            for (int i = 0; i < 9; i++) pulse(fib[i], 1'b0);
        end
        chk("t6_cnt3_sat", 32'(cnt3), 32'd7);
        chk("t6_cnt8",     32'(cnt8), 32'd9);
        chk("t6_err_none", 32'(err3), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fls_checker.md
Name: fls_checker

Overview:
- Receive-side companion to the FLS sequence generator.
- Samples a value stream strobed by `en`, the same interface FLS is driven with.
- Captures the first two values as seeds, then checks that every later value equals the sum of the previous two, modulo 2^W.
- Reports per-value match, a sticky error, a value count, the next expected value and its carry. Used as an on-board or in-bench monitor placed downstream of FLS.

Parameters:
- W, 8, data width of `d` and `exp`.
- CW, 8, width of the value counter `cnt`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  value strobe, level signal; its rising edge marks one value.
- clr  input  1  synchronous restart of checking.
- d  input  W  observed sequence value, sampled on an `en` rising edge.
- exp  output  W  next expected value.
- cf  output  1  carry out of the sum that produced `exp`.
- match  output  1  the last accepted value was correct (seeds count as correct).
- err  output  1  sticky; a mismatch has occurred since reset or `clr`.
- cnt  output  CW  number of values accepted, saturating.
- state  output  2  current FSM state, for debug.

Behaviour:
- Strobe detection:
  - `en_q` is a registered copy of `en`; `stb = en & ~en_q`.
  - Reset value of `en_q` is 0, so `en` already high when reset deasserts produces a strobe at the first clock edge after reset.
  - `en` held high for N cycles produces exactly one strobe.
- Reset: `state`=SEED0, internal `a`=0, `b`=0, `exp`=0, `cf`=0, `match`=0, `err`=0, `cnt`=0, `en_q`=0. Reset asserted mid-sequence discards all history immediately.
- State encoding: SEED0=0, SEED1=1, CHECK=2; 3 is unused and recovers to SEED0.
- SEED0, on `stb`:
  - `a` <= `d`, `match` <= 1, `cnt` <= 1; go to SEED1.
- SEED1, on `stb`:
  - `b` <= `d`, `{cf,exp}` <= `a` + `d` (W+1 bit sum), `match` <= 1, `cnt` <= 2; go to CHECK.
- CHECK, on `stb`:
  - `match` <= (`d` == `exp`); `err` <= `err` | (`d` != `exp`).
  - Resync to the received value: `a` <= `b`, `b` <= `d`, `{cf,exp}` <= `b` + `d`.
  - Stay in CHECK.
- No `stb`: all outputs hold.
- `clr`:
  - Forces the reset values of every output except `en_q`, which keeps tracking `en`. State returns to SEED0.
  - `clr` has priority over a simultaneous `stb`; that value is discarded.
- `cnt` increments on every accepted value and saturates at 2^CW-1; it never wraps.
- Arithmetic: unsigned, modulo 2^W; `cf` is bit W of the sum. `cf` is not an error condition.
- Latency: all outputs are registered. Values reflect a strobe sampled at edge k from edge k onward (visible the following cycle). Combinational path from `d`/`en` to outputs: none.

Decomposition:
- Package `fls_pkg`:
  - default W=8;
  - state type/localparams SEED0, SEED1, CHECK;
  - the W+1 bit sum helper function, shared with FLS.
- One natural sub-module: `fls_edge_det` (registered rising-edge detector, async active-high reset), reusable by FLS.
- The FSM and datapath stay in `fls_checker`.

Test Plan:
1. Reset release with `en` already high: `rst`=1 until 8 ns, `en`=1 at 3 ns, `d`=2 → one strobe at the first edge after reset; `cnt`=1, `state`=SEED1, `match`=1. Holding `en` high adds no further strobes.
2. Seeds 2,3 then 5,8,13 over five `en` pulses → after the seeds `exp`=5; after each value `exp` = 8, 13, 21; `match`=1 throughout, `err`=0, `cnt`=5, `cf`=0.
3. Overflow: seeds 144, 233 → `exp`=121, `cf`=1. Then `d`=121 → `match`=1, `exp`=98 (233+121=354 mod 256), `cf`=1.
4. Mismatch and resync: seeds 1,1, then `d`=3 (expected 2) → `match`=0, `err`=1, `exp`=4. Then `d`=4 → `match`=1, `err` remains 1.
5. `clr` together with a strobe in CHECK → SEED0, `cnt`=0, `err`=0, `match`=0, value discarded. The next two strobes reseed correctly.
6. Async reset mid-CHECK, asserted between clock edges → outputs zero immediately without waiting for a clock edge. `cnt` saturation: with CW=3, 9 strobes → `cnt`=7.
